mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative 32-bit multiply/divide unit beside the ALU in the EX stage of the MIPS pipeline.
- Takes both register-file read operands (after the forwarding muxes) and produces the architectural HI/LO registers used by mfhi/mflo.
- Runs for a fixed number of cycles; asserts busy so the hazard logic stalls IF/ID/EX.
- Also serves mthi/mtlo writes.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration counter width; must be ≥ clog2(WIDTH)+1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-low; clears all state while low.
- start  input  1  launch an operation (one-cycle pulse from EX decode).
- op  input  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- data1  input  WIDTH  rs operand: multiplicand or dividend.
- data2  input  WIDTH  rt operand: multiplier or divisor.
- kill  input  1  flush; aborts an in-flight operation.
- hi_we  input  1  mthi write strobe.
- lo_we  input  1  mtlo write strobe.
- wdata  input  WIDTH  mthi/mtlo data.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- busy  output  1  operation in flight; pipeline must stall.
- done  output  1  one-cycle pulse; HI/LO just updated.

Behaviour:
- Reset (rst low, asynchronous): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, internal datapath regs=0.
- FSM states: IDLE, RUN, FIXUP.
- IDLE:
  - start=1 at an edge latches op and absolute values of the operands (absolute values for signed ops only), records the result sign(s), loads counter=WIDTH, and moves to RUN.
  - busy=1 from the cycle after that edge.
- RUN:
  - Performs one radix-2 step per edge and decrements the counter.
  - Multiply: shift-add of magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract; remainder WIDTH+1 bits, quotient WIDTH bits.
  - Exits to FIXUP on the edge where counter reaches 0.
- FIXUP:
  - Applies sign correction and writes hi/lo.
  - Returns to IDLE; busy=0 and done=1 in the following cycle.
- Latency: start sampled at edge 0 → hi/lo valid and done=1 after edge WIDTH+1 (33). busy is high for exactly WIDTH+1 cycles.
- done is registered: high for exactly one cycle, otherwise 0.
- Result mapping:
  - mult/multu: {hi,lo} = full 2*WIDTH product; signed mult negates the product when the operand signs differ.
  - div/divu: lo = quotient, hi = remainder. Signed: quotient truncates toward zero, remainder takes the sign of the dividend.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (either div op): same latency; hi=data1 as latched, lo=all ones. No other error indication.
- start while busy: ignored; the in-flight operation is unaffected.
- kill:
  - In RUN or FIXUP: return to IDLE next edge, busy=0, done=0, hi/lo unchanged.
  - kill and start on the same edge in IDLE: kill wins, no launch.
- hi_we/lo_we:
  - Honoured only in IDLE with start=0; hi or lo takes wdata at the edge.
  - Both may write on the same edge.
  - Ignored while busy.
  - If start=1 on the same edge, start wins and the writes are dropped.
- Reset asserted mid-operation: immediate return to the reset values above; no partial result is visible.
- Operands are sampled only at the start edge; data1/data2 may change during RUN without effect.

Test Plan:
- Reset low mid-RUN (cycle 10 of a mult) → hi=lo=0, busy=0 immediately; after release, a fresh mult 6*7 → lo=0x0000002A, hi=0 at cycle 33.
- mult, data1=0xFFFFFFFD (-3), data2=5 → busy 33 cycles; done at cycle 33; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu, data1=data2=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; a second start pulse at cycle 5 is ignored and the result is unchanged.
- div, data1=0xFFFFFFF9 (-7), data2=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- divu, data1=0x1234, data2=0 → done at cycle 33, hi=0x00001234, lo=0xFFFFFFFF.
- Preload hi=0xAAAA0000, lo=0x5555 via hi_we/lo_we, start mult, assert kill at cycle 12 → busy drops next cycle, done never pulses, hi/lo keep 0xAAAA0000/0x00005555.

Source files
------------

// File: rtl/mul_div_unit_if.sv
// Handshake and data bundle between the EX stage and the iterative multiply/divide unit.
// The master drives the operation request and mthi/mtlo writes; the slave returns HI/LO and status.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             kill;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    modport master (
        output start, op, data1, data2, kill, hi_we, lo_we, wdata,
        input  hi, lo, busy, done
    );

    modport slave (
        input  start, op, data1, data2, kill, hi_we, lo_we, wdata,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit driving the architectural HI/LO registers.
// Magnitudes are processed in RUN (shift-add or restoring divide); signs are applied in FIXUP.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          rst,
    mul_div_unit_if.slave bus
);
    localparam logic [1:0]       ST_IDLE  = 2'd0;
    localparam logic [1:0]       ST_RUN   = 2'd1;
    localparam logic [1:0]       ST_FIXUP = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        logic [WIDTH-1:0] m;
        if (is_signed && v[WIDTH-1]) begin
            m = -v;
        end else begin
            m = v;
        end
        return m;
    endfunction

    logic [1:0]         state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               is_div_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic [WIDTH-1:0]   mag_a_r;
    logic [WIDTH-1:0]   mag_b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic               sgn_op_s;
    logic               d2_zero_s;
    logic [WIDTH-1:0]   abs1_s;
    logic [WIDTH-1:0]   abs2_s;
    logic               neg_q_s;
    logic               neg_r_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     div_shift_s;
    logic [WIDTH:0]     div_diff_s;
    logic               div_ok_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_fix_s;

    // Launch-time operand decode and the per-step multiply/divide arithmetic.
    always_comb begin
        sgn_op_s  = ~bus.op[0];
        d2_zero_s = (bus.data2 == {WIDTH{1'b0}});
        abs1_s    = magnitude(bus.data1, sgn_op_s);
        abs2_s    = magnitude(bus.data2, sgn_op_s);
        neg_q_s   = 1'b0;
        neg_r_s   = 1'b0;
        if (sgn_op_s) begin
            // A zero divisor must leave the all-ones quotient un-negated.
            neg_q_s = (bus.data1[WIDTH-1] ^ bus.data2[WIDTH-1]) & ~(bus.op[1] & d2_zero_s);
            neg_r_s = bus.op[1] & bus.data1[WIDTH-1];
        end else begin
            neg_q_s = 1'b0;
            neg_r_s = 1'b0;
        end
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                    + (acc_r[0] ? {1'b0, mag_a_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {rem_r, mag_a_r[WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, mag_b_r};
        div_ok_s    = ~div_diff_s[WIDTH];
        prod_s      = neg_q_r ? -acc_r : acc_r;
        quo_s       = neg_q_r ? -mag_a_r : mag_a_r;
        rem_fix_s   = neg_r_r ? -rem_r : rem_r;
    end

    // Sequencer, iterative datapath and architectural HI/LO registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            mag_a_r  <= {WIDTH{1'b0}};
            mag_b_r  <= {WIDTH{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (!bus.kill) begin
                            is_div_r <= bus.op[1];
                            neg_q_r  <= neg_q_s;
                            neg_r_r  <= neg_r_s;
                            mag_a_r  <= abs1_s;
                            mag_b_r  <= abs2_s;
                            acc_r    <= {{WIDTH{1'b0}}, abs2_s};
                            rem_r    <= {WIDTH{1'b0}};
                            cnt_r    <= CNT_LOAD;
                            busy_r   <= 1'b1;
                            state_r  <= ST_RUN;
                        end
                    end else begin
                        if (bus.hi_we) begin
                            hi_r <= bus.wdata;
                        end
                        if (bus.lo_we) begin
                            lo_r <= bus.wdata;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.kill) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        if (is_div_r) begin
                            rem_r   <= div_ok_s ? div_diff_s[WIDTH-1:0] : div_shift_s[WIDTH-1:0];
                            mag_a_r <= {mag_a_r[WIDTH-2:0], div_ok_s};
                        end else begin
                            acc_r   <= {mul_sum_s, acc_r[WIDTH-1:1]};
                        end
                        cnt_r <= cnt_r - CNT_ONE;
                        if (cnt_r == CNT_ONE) begin
                            state_r <= ST_FIXUP;
                        end
                    end
                end
                ST_FIXUP: begin
                    if (!bus.kill) begin
                        if (is_div_r) begin
                            hi_r <= rem_fix_s;
                            lo_r <= quo_s;
                        end else begin
                            hi_r <= prod_s[2*WIDTH-1:WIDTH];
                            lo_r <= prod_s[WIDTH-1:0];
                        end
                        done_r <= 1'b1;
                    end
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios plus randomized operations
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mul_div_unit_if #(.WIDTH(WIDTH)) bus ();

    mul_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "simulation time limit reached");
    end

    // Reference: {hi,lo} from MIPS mult/multu/div/divu rules using 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: res = 64'(sa * sb);
            2'b01: res = {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFFFFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFFFFFF};
                else            res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h00000000;
            1: return 32'h00000001;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic idle_inputs();
        bus.start = 1'b0; bus.op = 2'b00; bus.data1 = 32'd0; bus.data2 = 32'd0;
        bus.kill = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = 32'd0;
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1; bus.op = op; bus.data1 = a; bus.data2 = b;
    endtask

    // Clocks edge 0..n after a launch; optional stray start/write at poke_at, kill at kill_at.
    task automatic run_cycles(input int n, input int poke_at, input int kill_at,
                              output int done_cycle, output int done_cnt, output int busy_cnt);
        done_cycle = 0; done_cnt = 0; busy_cnt = 0;
        for (int c = 0; c <= n; c++) begin
            @(posedge clk); #1;
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cycle == 0) done_cycle = c;
            end
            bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.kill = 1'b0;
            bus.data1 = $urandom; bus.data2 = $urandom;
            if (c + 1 == poke_at) begin
                bus.start = 1'b1; bus.op = 2'($urandom_range(0, 3));
                bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = $urandom;
            end
            if (c + 1 == kill_at) bus.kill = 1'b1;
        end
    endtask

    task automatic write_hilo(input logic [31:0] hv, input logic [31:0] lv);
        bus.hi_we = 1'b1; bus.wdata = hv;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = lv;
        @(posedge clk); #1;
        bus.lo_we = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
        n_checks++; if (bus.lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: busy=%b done=%b expected 0 0", bus.busy, bus.done); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult_signed();
        int dc, dn, bc;
        launch(2'b00, 32'hFFFFFFFD, 32'd5);
        run_cycles(36, 0, 0, dc, dn, bc);
        n_checks++; if (bc !== 33) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d expected 33", bc); end
        n_checks++; if (dc !== 33 || dn !== 1) begin n_fail++; $display("FAIL mult_done: cycle %0d count %0d expected 33 1", dc, dn); end
        n_checks++; if (bus.hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", bus.hi); end
        n_checks++; if (bus.lo !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffff1", bus.lo); end
    endtask

    task automatic test_multu_start_ignored();
        int dc, dn, bc;
        launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_cycles(36, 5, 0, dc, dn, bc);
        n_checks++; if (dc !== 33 || dn !== 1) begin n_fail++; $display("FAIL multu_done: cycle %0d count %0d expected 33 1", dc, dn); end
        n_checks++; if (bus.hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h expected fffffffe", bus.hi); end
        n_checks++; if (bus.lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h expected 00000001", bus.lo); end
    endtask

    task automatic test_div_signed();
        int dc, dn, bc;
        launch(2'b10, 32'hFFFFFFF9, 32'd2);
        run_cycles(36, 0, 0, dc, dn, bc);
        n_checks++; if (bus.lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo: got %h expected fffffffd", bus.lo); end
        n_checks++; if (bus.hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi: got %h expected ffffffff", bus.hi); end
        launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
        run_cycles(36, 0, 0, dc, dn, bc);
        n_checks++; if (bus.lo !== 32'h80000000) begin n_fail++; $display("FAIL div_ovf_lo: got %h expected 80000000", bus.lo); end
        n_checks++; if (bus.hi !== 32'h00000000) begin n_fail++; $display("FAIL div_ovf_hi: got %h expected 0", bus.hi); end
    endtask

    task automatic test_divu_by_zero();
        int dc, dn, bc;
        launch(2'b11, 32'h00001234, 32'd0);
        run_cycles(36, 0, 0, dc, dn, bc);
        n_checks++; if (dc !== 33) begin n_fail++; $display("FAIL divz_done_cycle: got %0d expected 33", dc); end
        n_checks++; if (bus.hi !== 32'h00001234) begin n_fail++; $display("FAIL divz_hi: got %h expected 00001234", bus.hi); end
        n_checks++; if (bus.lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divz_lo: got %h expected ffffffff", bus.lo); end
    endtask

    task automatic test_kill();
        int dc, dn, bc;
        write_hilo(32'hAAAA0000, 32'h00005555);
        launch(2'b00, $urandom, $urandom);
        run_cycles(40, 0, 12, dc, dn, bc);
        n_checks++; if (bc !== 12) begin n_fail++; $display("FAIL kill_busy_cycles: got %0d expected 12", bc); end
        n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL kill_done: got %0d pulses expected 0", dn); end
        n_checks++; if (bus.hi !== 32'hAAAA0000 || bus.lo !== 32'h00005555) begin
            n_fail++; $display("FAIL kill_hilo: got %h/%h expected aaaa0000/00005555", bus.hi, bus.lo); end
    endtask

    task automatic test_write_rules();
        int dc, dn, bc;
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hCAFE0001;
        @(posedge clk); #1;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        n_checks++; if (bus.hi !== 32'hCAFE0001 || bus.lo !== 32'hCAFE0001) begin
            n_fail++; $display("FAIL dual_write: got %h/%h expected cafe0001/cafe0001", bus.hi, bus.lo); end
        launch(2'b01, 32'd3, 32'd4);
        bus.kill = 1'b1;
        run_cycles(4, 0, 0, dc, dn, bc);
        n_checks++; if (bc !== 0 || dn !== 0) begin n_fail++; $display("FAIL kill_beats_start: busy %0d done %0d expected 0 0", bc, dn); end
        launch(2'b01, 32'd3, 32'd4);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h0000DEAD;
        run_cycles(6, 0, 3, dc, dn, bc);
        n_checks++; if (bc !== 3) begin n_fail++; $display("FAIL start_with_write_busy: got %0d expected 3", bc); end
        n_checks++; if (bus.hi !== 32'hCAFE0001 || bus.lo !== 32'hCAFE0001) begin
            n_fail++; $display("FAIL start_drops_write: got %h/%h expected cafe0001/cafe0001", bus.hi, bus.lo); end
    endtask

    task automatic test_reset_mid_run();
        int dc, dn, bc;
        write_hilo(32'h00001111, 32'h00002222);
        launch(2'b00, $urandom, $urandom);
        run_cycles(10, 0, 0, dc, dn, bc);
        rst = 1'b0;
        #2;
        n_checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin
            n_fail++; $display("FAIL midrun_reset_hilo: got %h/%h expected 0/0", bus.hi, bus.lo); end
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset_flags: busy=%b done=%b expected 0 0", bus.busy, bus.done); end
        @(posedge clk); #1;
        rst = 1'b1;
        launch(2'b00, 32'd6, 32'd7);
        run_cycles(36, 0, 0, dc, dn, bc);
        n_checks++; if (dc !== 33) begin n_fail++; $display("FAIL post_reset_done_cycle: got %0d expected 33", dc); end
        n_checks++; if (bus.lo !== 32'h0000002A || bus.hi !== 32'd0) begin
            n_fail++; $display("FAIL post_reset_mult: got %h/%h expected 00000000/0000002a", bus.hi, bus.lo); end
    endtask

    task automatic test_random();
        int dc, dn, bc;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp_v;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            exp_v = model(op, a, b);
            launch(op, a, b);
            run_cycles(36, 0, 0, dc, dn, bc);
            n_checks++; if ({bus.hi, bus.lo} !== exp_v || dc !== 33) begin
                n_fail++; $display("FAIL random_op%0d: op=%0d a=%h b=%h got %h_%h at %0d expected %h at 33",
                                   i, op, a, b, bus.hi, bus.lo, dc, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        int dc, dn, bc;
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp_v;
        for (int i = 0; i < 6; i++) begin
            op = 2'(i % 4);
            a = $urandom;
            b = $urandom_range(1, 1000);
            exp_v = model(op, a, b);
            launch(op, a, b);
            run_cycles(33, 0, 0, dc, dn, bc);
            n_checks++; if ({bus.hi, bus.lo} !== exp_v || dc !== 33 || bc !== 33) begin
                n_fail++; $display("FAIL back_to_back%0d: got %h_%h done %0d busy %0d expected %h done 33 busy 33",
                                   i, bus.hi, bus.lo, dc, bc, exp_v); end
        end
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_multu_start_ignored();
        test_div_signed();
        test_divu_by_zero();
        test_kill();
        test_write_rules();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
